// File: rtl/sys_defs.sv
// Shared execute/complete definitions: FU population, flattened FU id offsets,
// function-type encoding and the EX_CO_PACKET handed from execute to complete.
package sys_defs;

  localparam int NUM_ALU    = 3;
  localparam int NUM_MULT   = 2;
  localparam int NUM_BRANCH = 1;
  localparam int NUM_LOAD   = 1;
  localparam int NUM_STORE  = 1;

  localparam int NUM_FU_TOTAL = NUM_ALU + NUM_MULT + NUM_BRANCH + NUM_LOAD + NUM_STORE;

  // Flattened FU ids: ALU first, then MULT, BRANCH, LOAD, STORE.
  localparam int ALU_BASE    = 0;
  localparam int MULT_BASE   = ALU_BASE + NUM_ALU;
  localparam int BRANCH_BASE = MULT_BASE + NUM_MULT;
  localparam int LOAD_BASE   = BRANCH_BASE + NUM_BRANCH;
  localparam int STORE_BASE  = LOAD_BASE + NUM_LOAD;

  localparam int FU_IDX_W = $clog2(NUM_FU_TOTAL);
  localparam int ROB_W    = 5;
  localparam int XLEN     = 32;

  typedef enum logic [2:0] {
    FUNC_ALU    = 3'd0,
    FUNC_MULT   = 3'd1,
    FUNC_BRANCH = 3'd2,
    FUNC_LOAD   = 3'd3,
    FUNC_STORE  = 3'd4
  } FUNC_TYPE;

  typedef struct packed {
    logic                valid;
    logic [ROB_W-1:0]    rob_index;
    FUNC_TYPE            function_type;
    logic [FU_IDX_W-1:0] issued_fu_index;
    logic [XLEN-1:0]     result;
  } EX_CO_PACKET;

endpackage

// File: rtl/ex_co_rr_arbiter.sv
// Purely combinational round-robin arbiter: first requester at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant plus encoded index.
module ex_co_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    logic [IDX_W:0] pos;
    logic           take;
    pos         = '0;
    take        = 1'b0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos         = {1'b0, ptr} + (IDX_W+1)'(k);
      pos         = (pos >= (IDX_W+1)'(NUM_REQ)) ? pos - (IDX_W+1)'(NUM_REQ) : pos;
      take        = !grant_valid && req[pos[IDX_W-1:0]];
      grant_idx   = take ? pos[IDX_W-1:0] : grant_idx;
      grant_valid = grant_valid | take;
    end
    grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/ex_co_arbiter.sv
// Execute->complete result arbiter: one holding slot per FU, one registered result per cycle.
// Optional macro EX_CO_BRANCH_PRIORITY_EN lets branch results overtake round-robin order.
module ex_co_arbiter import sys_defs::*; #(
  parameter int NUM_REQ = NUM_FU_TOTAL,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rollback,
  input  logic [NUM_REQ-1:0] fu_done_valid,
  input  EX_CO_PACKET        fu_done_packet [NUM_REQ],
  output logic [NUM_REQ-1:0] fu_done_ready,
  output EX_CO_PACKET        ex_co_reg,
  output logic [IDX_W:0]     pending_count
);

  EX_CO_PACKET        slot [NUM_REQ];
  EX_CO_PACKET        cand [NUM_REQ];
  EX_CO_PACKET        win_pkt;
  logic [NUM_REQ-1:0] slot_valid, slot_valid_nxt, load_slot, req;
  logic [NUM_REQ-1:0] rr_grant, grant;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, rr_idx, grant_idx;
  logic               rr_valid, grant_valid;

  function automatic logic [IDX_W:0] count_ones(input logic [NUM_REQ-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQ; i++) n = n + {{IDX_W{1'b0}}, v[i]};
    return n;
  endfunction

  // A full slot back-pressures its FU until the held result is granted.
  assign fu_done_ready = ~slot_valid;
  assign req           = slot_valid | fu_done_valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cand[i] = slot_valid[i] ? slot[i] : fu_done_packet[i];
  end

  ex_co_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

`ifdef EX_CO_BRANCH_PRIORITY_EN
  logic [NUM_REQ-1:0] br_req;
  logic [IDX_W-1:0]   br_idx;

  // Lowest-index branch candidate overrides the round-robin winner.
  always_comb begin
    br_req = '0;
    br_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      br_req[i] = req[i] && (cand[i].function_type == FUNC_BRANCH);
      br_idx    = br_req[i] ? IDX_W'(i) : br_idx;
    end
    grant_valid = rr_valid;
    grant_idx   = (|br_req) ? br_idx : rr_idx;
    grant       = (|br_req) ? (NUM_REQ'(1) << br_idx) : rr_grant;
  end
`else
  always_comb begin
    grant_valid = rr_valid;
    grant_idx   = rr_idx;
    grant       = rr_grant;
  end
`endif

  always_comb begin
    win_pkt        = cand[grant_idx];
    win_pkt.valid  = 1'b1;
    slot_valid_nxt = (slot_valid | fu_done_valid) & ~grant;
    load_slot      = fu_done_valid & ~slot_valid & ~grant;
    rr_ptr_nxt     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Control state; rollback drops every held and incoming result but keeps rr_ptr.
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_valid    <= '0;
      rr_ptr        <= '0;
      ex_co_reg     <= '0;
      pending_count <= '0;
    end else if (rollback) begin
      slot_valid    <= '0;
      ex_co_reg     <= '0;
      pending_count <= '0;
    end else begin
      slot_valid    <= slot_valid_nxt;
      rr_ptr        <= grant_valid ? rr_ptr_nxt : rr_ptr;
      ex_co_reg     <= grant_valid ? win_pkt : '0;
      pending_count <= count_ones(slot_valid_nxt);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load_slot[i]) slot[i] <= fu_done_packet[i];
    end
  end

endmodule

// File: tb/tb_ex_co_arbiter.sv
// Directed scoreboard bench for ex_co_arbiter; expected packets are queued in
// emission order and popped whenever the DUT presents a valid result.
module tb_ex_co_arbiter import sys_defs::*; ;

  localparam int N  = NUM_FU_TOTAL;
  localparam int IW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rollback = 1'b0;
  logic [N-1:0]  fu_done_valid = '0;
  logic [N-1:0]  fu_done_ready;
  EX_CO_PACKET   pkt [N];
  EX_CO_PACKET   ex_co_reg;
  logic [IW:0]   pending_count;

  int            checks = 0;
  int            failures = 0;
  EX_CO_PACKET   sb [$];
  EX_CO_PACKET   sb_exp;

  ex_co_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .rollback       (rollback),
    .fu_done_valid  (fu_done_valid),
    .fu_done_packet (pkt),
    .fu_done_ready  (fu_done_ready),
    .ex_co_reg      (ex_co_reg),
    .pending_count  (pending_count)
  );

  always #5 clock = ~clock;

  function automatic EX_CO_PACKET mk(input int fu, input int rob, input FUNC_TYPE ft);
    EX_CO_PACKET p;
    p.valid           = 1'b1;
    p.rob_index       = ROB_W'(rob);
    p.function_type   = ft;
    p.issued_fu_index = FU_IDX_W'(fu);
    p.result          = 32'h1000_0000 + 32'(fu * 256 + rob);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && ex_co_reg.valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(ex_co_reg), 64'(0));
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_pkt", 64'(ex_co_reg), 64'(sb_exp));
      end
    end
  end

  initial begin
    int cnt [N];
    int seq [N];
    logic [N-1:0] hs;

    for (int i = 0; i < N; i++) pkt[i] = mk(i, i, FUNC_ALU);

    // 1: reset held low with every FU asserting valid
    fu_done_valid = '1;
    tick();
    chk("rst_valid_c1", 64'(ex_co_reg.valid), 64'(0));
    chk("rst_pend_c1", 64'(pending_count), 64'(0));
    tick();
    chk("rst_valid_c2", 64'(ex_co_reg.valid), 64'(0));
    chk("rst_pend_c2", 64'(pending_count), 64'(0));
    reset = 1'b1;
    fu_done_valid = '0;
    chk("rst_ready", 64'(fu_done_ready), 64'({N{1'b1}}));
    tick();
    chk("idle_valid", 64'(ex_co_reg.valid), 64'(0));

    // 2: lone request bypasses the slot
    pkt[3] = mk(3, 7, FUNC_ALU);
    sb.push_back(mk(3, 7, FUNC_ALU));
    fu_done_valid = 8'b0000_1000;
    tick();
    fu_done_valid = '0;
    chk("lone_valid", 64'(ex_co_reg.valid), 64'(1));
    chk("lone_rob", 64'(ex_co_reg.rob_index), 64'(7));
    chk("lone_pend", 64'(pending_count), 64'(0));
    chk("lone_ready", 64'(fu_done_ready), 64'({N{1'b1}}));

    // FU7 alone wraps the pointer back to 0
    pkt[7] = mk(7, 1, FUNC_ALU);
    sb.push_back(mk(7, 1, FUNC_ALU));
    fu_done_valid = 8'b1000_0000;
    tick();
    fu_done_valid = '0;

    // 3: FUs 0,1,2 together drain in index order
    for (int i = 0; i < 3; i++) begin
      pkt[i] = mk(i, 2, FUNC_ALU);
      sb.push_back(mk(i, 2, FUNC_ALU));
    end
    fu_done_valid = 8'b0000_0111;
    tick();
    fu_done_valid = '0;
    chk("trio_fu0", 64'(ex_co_reg.issued_fu_index), 64'(0));
    chk("trio_pend2", 64'(pending_count), 64'(2));
    chk("trio_ready_a", 64'(fu_done_ready), 64'(8'hF9));
    tick();
    chk("trio_fu1", 64'(ex_co_reg.issued_fu_index), 64'(1));
    chk("trio_pend1", 64'(pending_count), 64'(1));
    chk("trio_ready_b", 64'(fu_done_ready), 64'(8'hFB));
    tick();
    chk("trio_fu2", 64'(ex_co_reg.issued_fu_index), 64'(2));
    chk("trio_pend0", 64'(pending_count), 64'(0));
    chk("trio_ready_c", 64'(fu_done_ready), 64'(8'hFF));

    // 4: saturation, pointer now at 3; 24 cycles of valid, 31 results total
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      seq[i] = 0;
      pkt[i] = mk(i, i, FUNC_ALU);
    end
    for (int g = 0; g < 31; g++) begin
      int fu;
      fu = (3 + g) % N;
      sb.push_back(mk(fu, cnt[fu] * 8 + fu, FUNC_ALU));
      cnt[fu]++;
    end
    fu_done_valid = '1;
    for (int c = 0; c < 3 * N; c++) begin
      hs = fu_done_valid & fu_done_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          seq[i]++;
          pkt[i] = mk(i, seq[i] * 8 + i, FUNC_ALU);
        end
      end
    end
    fu_done_valid = '0;
    chk("sat_pend7", 64'(pending_count), 64'(7));
    repeat (7) tick();
    chk("sat_pend0", 64'(pending_count), 64'(0));
    tick();
    chk("sat_idle", 64'(ex_co_reg.valid), 64'(0));

    // 5: pointer at 2; park FU1 and FU4 in slots, then roll back with FU2 arriving
    pkt[1] = mk(1, 20, FUNC_ALU);
    pkt[2] = mk(2, 21, FUNC_ALU);
    pkt[4] = mk(4, 22, FUNC_ALU);
    sb.push_back(mk(2, 21, FUNC_ALU));
    fu_done_valid = 8'b0001_0110;
    tick();
    fu_done_valid = '0;
    chk("rb_pre_pend", 64'(pending_count), 64'(2));
    chk("rb_pre_ready", 64'(fu_done_ready), 64'(8'hED));
    rollback = 1'b1;
    pkt[2] = mk(2, 23, FUNC_ALU);
    fu_done_valid = 8'b0000_0100;
    tick();
    rollback = 1'b0;
    fu_done_valid = '0;
    chk("rb_valid", 64'(ex_co_reg.valid), 64'(0));
    chk("rb_pend", 64'(pending_count), 64'(0));
    chk("rb_ready", 64'(fu_done_ready), 64'({N{1'b1}}));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rb_quiet", 64'(ex_co_reg.valid), 64'(0));
    end

    // 6: pointer at 3; FU7 alone returns it to 0, then ALU FU0 against BRANCH FU5
    pkt[7] = mk(7, 2, FUNC_ALU);
    sb.push_back(mk(7, 2, FUNC_ALU));
    fu_done_valid = 8'b1000_0000;
    tick();
    fu_done_valid = '0;
    pkt[ALU_BASE]    = mk(ALU_BASE, 24, FUNC_ALU);
    pkt[BRANCH_BASE] = mk(BRANCH_BASE, 25, FUNC_BRANCH);
`ifdef EX_CO_BRANCH_PRIORITY_EN
    sb.push_back(mk(BRANCH_BASE, 25, FUNC_BRANCH));
    sb.push_back(mk(ALU_BASE, 24, FUNC_ALU));
`else
    sb.push_back(mk(ALU_BASE, 24, FUNC_ALU));
    sb.push_back(mk(BRANCH_BASE, 25, FUNC_BRANCH));
`endif
    fu_done_valid = 8'b0010_0001;
    tick();
    fu_done_valid = '0;
`ifdef EX_CO_BRANCH_PRIORITY_EN
    chk("prio_first", 64'(ex_co_reg.issued_fu_index), 64'(BRANCH_BASE));
    tick();
    chk("prio_second", 64'(ex_co_reg.issued_fu_index), 64'(ALU_BASE));
`else
    chk("prio_first", 64'(ex_co_reg.issued_fu_index), 64'(ALU_BASE));
    tick();
    chk("prio_second", 64'(ex_co_reg.issued_fu_index), 64'(BRANCH_BASE));
`endif
    tick();
    chk("end_idle", 64'(ex_co_reg.valid), 64'(0));
    chk("end_pend", 64'(pending_count), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
